cmos_dvp_capture: RTL and testbench
===================================

CMOS_DVP_CAPTURE -- requirements
Module: cmos_dvp_capture

Interface
REQ-001 SHALL have parameter DW, default 8, sensor data bus width (8 or 10).
REQ-002 SHALL have parameter BPP, default 2, bytes per pixel (1, 2 or 3).
REQ-003 SHALL have parameter SKIP_FRAMES, default 10, frames discarded after enable (0..255).
REQ-004 SHALL have parameter VS_ACT_LOW, default 1, 1 = CMOS_VSYNC low during active frame.
REQ-005 SHALL have parameter HREF_ACT_HIGH, default 1, 1 = CMOS_HREF high during active line.
REQ-006 iCLK  in  1  pixel clock (sensor PCLK); the only clock.
REQ-007 iRST  in  1  asynchronous, active-high reset.
REQ-008 Init_Done  in  1  sensor I2C initialisation complete.
REQ-009 cfg_en  in  1  capture enable.
REQ-010 CMOS_iDATA  in  DW  sensor data.
REQ-011 CMOS_VSYNC, CMOS_HREF  in  1 each  sensor syncs, polarity per parameters.
REQ-012 pix_data  out  BPP*DW  assembled pixel; first byte of the pixel in the MSBs.
REQ-013 pix_valid  out  1  one-cycle strobe per pixel.
REQ-014 pix_x, pix_y  out  12 each  coordinates of the pixel on pix_data.
REQ-015 frame_start, frame_end, line_end  out  1 each  one-cycle strobes.
REQ-016 err_partial  out  1  one-cycle strobe: line ended mid-pixel.
REQ-017 frame_cnt  out  8  captured frames, wraps at 255 -> 0.
REQ-018 line_width  out  12  pixel count of the last completed line.

Function
REQ-019 SHALL register CMOS_iDATA/VSYNC/HREF once on entry; the polarity-normalised vs_act/hr_act derive from these registers.
REQ-020 SHALL implement FSM IDLE -> SKIP -> WAIT_VS -> CAPTURE.
REQ-021 IDLE: leave when Init_Done & cfg_en; go to SKIP, or to WAIT_VS if SKIP_FRAMES = 0.
REQ-022 SKIP: count vs_act falling edges; go to WAIT_VS after SKIP_FRAMES of them; no outputs asserted.
REQ-023 WAIT_VS: go to CAPTURE on the next vs_act rising edge, pulsing frame_start in the same cycle; a frame already active on entry is ignored.
REQ-024 CAPTURE: on vs_act falling edge pulse frame_end, increment frame_cnt, then return to WAIT_VS if cfg_en = 1, else IDLE.
REQ-025 cfg_en deassert mid-frame SHALL NOT abort; the current frame completes (REQ-024).
REQ-026 Init_Done deassert in any state SHALL force IDLE next cycle without frame_end.
REQ-027 In CAPTURE, while vs_act & hr_act, each cycle SHALL shift one byte into the pixel accumulator; byte counter wraps 0..BPP-1.
REQ-028 On the BPP-th byte, pix_data/pix_valid SHALL update on the next edge: latency = 2 iCLK edges from input byte to pix_valid.
REQ-029 pix_x SHALL start at 0 per line and increment after each pixel; pix_y SHALL start at 0 per frame and increment after each line_end; both saturate at 4095.
REQ-030 On hr_act falling edge in CAPTURE: pulse line_end, load line_width with the pixel count, reset pix_x and byte counter.
REQ-031 If the byte counter is nonzero at hr_act fall, the partial pixel SHALL be dropped and err_partial pulsed with line_end.
REQ-032 HREF active while vs_act inactive SHALL be ignored.
REQ-033 pix_data SHALL hold its value between strobes.

Reset
REQ-034 On iRST: FSM = IDLE; all outputs, counters and accumulators = 0, effective immediately and asynchronously.
REQ-035 Reset mid-frame SHALL require a full re-run of SKIP after release.

Verification
REQ-036 SKIP_FRAMES=2, BPP=2, enable, 4 frames of 4 lines x 8 bytes -> frame_start/frame_end only for frames 3-4, frame_cnt = 2, 4 pixels/line, line_width = 4.
REQ-037 BPP=2, bytes 0xA1, 0xB2 -> pix_data = 0xA1B2, pix_valid 2 edges after 0xB2 applied, pix_x = 0.
REQ-038 BPP=3, line of 7 bytes -> 2 pix_valid, err_partial with line_end, line_width = 2.
REQ-039 cfg_en dropped mid-frame 3 -> frame 3 completes with frame_end, FSM IDLE, no frame 4 strobes.
REQ-040 iRST asserted during line 2 -> all outputs 0 same cycle; after release SKIP repeats before next frame_start.
REQ-041 VS_ACT_LOW=0, HREF_ACT_HIGH=0 with inverted stimulus -> output identical to REQ-036.

Source files
------------

// File: rtl/cmos_dvp_capture_if.sv
// Sensor-side DVP signals plus the assembled pixel stream of the capture block.
`timescale 1ns/1ps
interface cmos_dvp_capture_if #(
    parameter int unsigned DW  = 8,
    parameter int unsigned BPP = 2
);
    logic              Init_Done;
    logic              cfg_en;
    logic [DW-1:0]     CMOS_iDATA;
    logic              CMOS_VSYNC;
    logic              CMOS_HREF;
    logic [BPP*DW-1:0] pix_data;
    logic              pix_valid;
    logic [11:0]       pix_x;
    logic [11:0]       pix_y;
    logic              frame_start;
    logic              frame_end;
    logic              line_end;
    logic              err_partial;
    logic [7:0]        frame_cnt;
    logic [11:0]       line_width;

    // Sensor / controller side
    modport master (
        output Init_Done, cfg_en, CMOS_iDATA, CMOS_VSYNC, CMOS_HREF,
        input  pix_data, pix_valid, pix_x, pix_y, frame_start, frame_end,
               line_end, err_partial, frame_cnt, line_width
    );

    // Capture block side
    modport slave (
        input  Init_Done, cfg_en, CMOS_iDATA, CMOS_VSYNC, CMOS_HREF,
        output pix_data, pix_valid, pix_x, pix_y, frame_start, frame_end,
               line_end, err_partial, frame_cnt, line_width
    );
endinterface

// File: rtl/cmos_dvp_capture.sv
// DVP camera capture: frame skipping after enable, byte-to-pixel assembly,
// pixel coordinates and frame/line strobes, all in the sensor PCLK domain.
`timescale 1ns/1ps
module cmos_dvp_capture #(
    parameter int unsigned DW            = 8,
    parameter int unsigned BPP           = 2,
    parameter int unsigned SKIP_FRAMES   = 10,
    parameter bit          VS_ACT_LOW    = 1'b1,
    parameter bit          HREF_ACT_HIGH = 1'b1
) (
    input logic               iCLK,
    input logic               iRST,
    cmos_dvp_capture_if.slave bus
);
    localparam int unsigned PW  = BPP * DW;
    localparam int unsigned CW  = 12;
    localparam int unsigned SKW = 8;
    localparam int unsigned BCW = (BPP > 1) ? $clog2(BPP) : 1;
    localparam logic [BCW-1:0] BC_LAST   = BCW'(BPP - 1);
    localparam logic [SKW-1:0] SKIP_LAST = SKW'(SKIP_FRAMES - 1);
    localparam logic [CW-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, SKIP, WAIT_VS, CAPTURE} state_t;

    state_t          state_q, state_nxt;
    logic [DW-1:0]   data_r;
    logic            vs_r, hr_r;
    logic            vs_act_d, hr_eff_d;
    logic [SKW-1:0]  skip_cnt;
    logic [BCW-1:0]  byte_cnt;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_nxt;
    logic [CW-1:0]   x_cnt, y_cnt;
    logic            fs_nxt, fe_nxt;

    logic vs_act, hr_act, hr_eff, vs_rise, vs_fall, hr_fall, capturing;

    // HREF only counts inside an active frame
    assign vs_act    = VS_ACT_LOW    ? ~vs_r : vs_r;
    assign hr_act    = HREF_ACT_HIGH ? hr_r  : ~hr_r;
    assign hr_eff    = hr_act & vs_act;
    assign vs_rise   = vs_act & ~vs_act_d;
    assign vs_fall   = ~vs_act & vs_act_d;
    assign hr_fall   = ~hr_eff & hr_eff_d;
    assign capturing = (state_q == CAPTURE);
    assign acc_nxt   = PW'({acc, data_r});

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state_q <= IDLE;
        else      state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        fs_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Init_Done && bus.cfg_en)
                    state_nxt = (SKIP_FRAMES == 0) ? WAIT_VS : SKIP;
            end
            SKIP: begin
                if (vs_fall && (skip_cnt == SKIP_LAST)) state_nxt = WAIT_VS;
            end
            WAIT_VS: begin
                if (vs_rise) begin
                    state_nxt = CAPTURE;
                    fs_nxt    = 1'b1;
                end
            end
            CAPTURE: begin
                if (vs_fall) begin
                    fe_nxt    = 1'b1;
                    state_nxt = bus.cfg_en ? WAIT_VS : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Losing sensor init abandons everything, including a frame in flight
        if (!bus.Init_Done) begin
            state_nxt = IDLE;
            fs_nxt    = 1'b0;
            fe_nxt    = 1'b0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            data_r          <= '0;
            vs_r            <= VS_ACT_LOW;
            hr_r            <= ~HREF_ACT_HIGH;
            vs_act_d        <= 1'b0;
            hr_eff_d        <= 1'b0;
            skip_cnt        <= '0;
            byte_cnt        <= '0;
            acc             <= '0;
            x_cnt           <= '0;
            y_cnt           <= '0;
            bus.pix_data    <= '0;
            bus.pix_valid   <= 1'b0;
            bus.pix_x       <= '0;
            bus.pix_y       <= '0;
            bus.frame_start <= 1'b0;
            bus.frame_end   <= 1'b0;
            bus.line_end    <= 1'b0;
            bus.err_partial <= 1'b0;
            bus.frame_cnt   <= '0;
            bus.line_width  <= '0;
        end else begin
            data_r          <= bus.CMOS_iDATA;
            vs_r            <= bus.CMOS_VSYNC;
            hr_r            <= bus.CMOS_HREF;
            vs_act_d        <= vs_act;
            hr_eff_d        <= hr_eff;
            bus.frame_start <= fs_nxt;
            bus.frame_end   <= fe_nxt;
            bus.pix_valid   <= 1'b0;
            bus.line_end    <= 1'b0;
            bus.err_partial <= 1'b0;

            if (fe_nxt) bus.frame_cnt <= bus.frame_cnt + 8'd1;

            if (state_q != SKIP) skip_cnt <= '0;
            else if (vs_fall)    skip_cnt <= skip_cnt + 8'd1;

            if (fs_nxt) begin
                x_cnt    <= '0;
                y_cnt    <= '0;
                byte_cnt <= '0;
            end else if (capturing && hr_eff) begin
                acc <= acc_nxt;
                if (byte_cnt == BC_LAST) begin
                    byte_cnt      <= '0;
                    bus.pix_valid <= 1'b1;
                    bus.pix_data  <= acc_nxt;
                    bus.pix_x     <= x_cnt;
                    bus.pix_y     <= y_cnt;
                    if (x_cnt != CNT_MAX) x_cnt <= x_cnt + 12'd1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (capturing && hr_fall) begin
                // Bytes of an unfinished pixel are simply abandoned in acc
                bus.line_end    <= 1'b1;
                bus.err_partial <= (byte_cnt != '0);
                bus.line_width  <= x_cnt;
                x_cnt           <= '0;
                byte_cnt        <= '0;
                if (y_cnt != CNT_MAX) y_cnt <= y_cnt + 12'd1;
            end
        end
    end
endmodule

// File: tb/tb_cmos_dvp_capture.sv
// Directed bench: three capture instances (2-byte, 3-byte, inverted-polarity) share one stimulus.
`timescale 1ns/1ps
module tb_cmos_dvp_capture;
    logic       iCLK = 1'b0;
    logic       rst;
    logic       init_done, cfg_en, vs_s, hr_s;
    logic [7:0] d_s;

    int n_checks = 0;
    int n_fail   = 0;

    int fs_a = 0, fe_a = 0, le_a = 0, pv_a = 0, ep_a = 0;
    int fs_b = 0, fe_b = 0, le_b = 0, pv_b = 0, ep_b = 0, eps_b = 0;
    int fs_c = 0, fe_c = 0, pv_c = 0;

    always #5 iCLK = ~iCLK;

    cmos_dvp_capture_if #(.DW(8), .BPP(2)) if_a ();
    cmos_dvp_capture_if #(.DW(8), .BPP(3)) if_b ();
    cmos_dvp_capture_if #(.DW(8), .BPP(2)) if_c ();

    assign if_a.Init_Done  = init_done;
    assign if_a.cfg_en     = cfg_en;
    assign if_a.CMOS_iDATA = d_s;
    assign if_a.CMOS_VSYNC = ~vs_s;
    assign if_a.CMOS_HREF  = hr_s;
    assign if_b.Init_Done  = init_done;
    assign if_b.cfg_en     = cfg_en;
    assign if_b.CMOS_iDATA = d_s;
    assign if_b.CMOS_VSYNC = ~vs_s;
    assign if_b.CMOS_HREF  = hr_s;
    assign if_c.Init_Done  = init_done;
    assign if_c.cfg_en     = cfg_en;
    assign if_c.CMOS_iDATA = d_s;
    assign if_c.CMOS_VSYNC = vs_s;
    assign if_c.CMOS_HREF  = ~hr_s;

    cmos_dvp_capture #(.DW(8), .BPP(2), .SKIP_FRAMES(2), .VS_ACT_LOW(1'b1), .HREF_ACT_HIGH(1'b1))
        dut_a (.iCLK(iCLK), .iRST(rst), .bus(if_a.slave));
    cmos_dvp_capture #(.DW(8), .BPP(3), .SKIP_FRAMES(0), .VS_ACT_LOW(1'b1), .HREF_ACT_HIGH(1'b1))
        dut_b (.iCLK(iCLK), .iRST(rst), .bus(if_b.slave));
    cmos_dvp_capture #(.DW(8), .BPP(2), .SKIP_FRAMES(2), .VS_ACT_LOW(1'b0), .HREF_ACT_HIGH(1'b0))
        dut_c (.iCLK(iCLK), .iRST(rst), .bus(if_c.slave));

    // Strobe counters, sampled mid-cycle
    always @(negedge iCLK) begin
        if (if_a.frame_start) fs_a++;
        if (if_a.frame_end)   fe_a++;
        if (if_a.line_end)    le_a++;
        if (if_a.pix_valid)   pv_a++;
        if (if_a.err_partial) ep_a++;
        if (if_b.frame_start) fs_b++;
        if (if_b.frame_end)   fe_b++;
        if (if_b.line_end)    le_b++;
        if (if_b.pix_valid)   pv_b++;
        if (if_b.err_partial) ep_b++;
        if (if_b.err_partial && !if_b.line_end) eps_b++;
        if (if_c.frame_start) fs_c++;
        if (if_c.frame_end)   fe_c++;
        if (if_c.pix_valid)   pv_c++;
    end

    task automatic cyc(input logic v, input logic h, input logic [7:0] d);
        @(posedge iCLK); #1;
        vs_s = v; hr_s = h; d_s = d;
    endtask

    task automatic send_line(input int l, input int nb);
        for (int i = 0; i < nb; i++) cyc(1'b1, 1'b1, 8'(l * 16 + i));
        repeat (2) cyc(1'b1, 1'b0, 8'h00);
    endtask

    task automatic frame_head();
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
        repeat (2) cyc(1'b1, 1'b0, 8'h00);
    endtask

    task automatic frame_tail();
        repeat (4) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int nl, input int nb);
        frame_head();
        for (int l = 0; l < nl; l++) send_line(l, nb);
        frame_tail();
    endtask

    task automatic test_reset();
        rst = 1'b1; init_done = 1'b0; cfg_en = 1'b0; vs_s = 1'b0; hr_s = 1'b0; d_s = 8'h00;
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        n_checks++; if (if_a.pix_data !== 16'h0) begin n_fail++; $display("FAIL reset_pix_data: got %0h want 0", if_a.pix_data); end
        n_checks++; if (if_a.pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pix_valid: got %0b want 0", if_a.pix_valid); end
        n_checks++; if (if_a.frame_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", if_a.frame_cnt); end
        n_checks++; if (if_a.line_width !== 12'h0) begin n_fail++; $display("FAIL reset_line_width: got %0d want 0", if_a.line_width); end
        n_checks++; if (if_b.pix_data !== 24'h0) begin n_fail++; $display("FAIL reset_b_pix_data: got %0h want 0", if_b.pix_data); end
        rst = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_skip_capture();
        int s_fs, s_fe, s_pv, s_le, s_fsc, s_pvc, exp_fr;
        init_done = 1'b1; cfg_en = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        for (int f = 0; f < 4; f++) begin
            s_fs = fs_a; s_fe = fe_a; s_pv = pv_a; s_le = le_a; s_fsc = fs_c; s_pvc = pv_c;
            send_frame(4, 8);
            exp_fr = (f >= 2) ? 1 : 0;
            n_checks++; if (fs_a - s_fs !== exp_fr) begin n_fail++; $display("FAIL skip_frame_start f%0d: got %0d want %0d", f, fs_a - s_fs, exp_fr); end
            n_checks++; if (fe_a - s_fe !== exp_fr) begin n_fail++; $display("FAIL skip_frame_end f%0d: got %0d want %0d", f, fe_a - s_fe, exp_fr); end
            n_checks++; if (pv_a - s_pv !== 16 * exp_fr) begin n_fail++; $display("FAIL skip_pixels f%0d: got %0d want %0d", f, pv_a - s_pv, 16 * exp_fr); end
            n_checks++; if (le_a - s_le !== 4 * exp_fr) begin n_fail++; $display("FAIL skip_line_end f%0d: got %0d want %0d", f, le_a - s_le, 4 * exp_fr); end
            n_checks++; if (fs_c - s_fsc !== exp_fr) begin n_fail++; $display("FAIL inv_frame_start f%0d: got %0d want %0d", f, fs_c - s_fsc, exp_fr); end
            n_checks++; if (pv_c - s_pvc !== 16 * exp_fr) begin n_fail++; $display("FAIL inv_pixels f%0d: got %0d want %0d", f, pv_c - s_pvc, 16 * exp_fr); end
        end
        n_checks++; if (if_a.frame_cnt !== 8'd2) begin n_fail++; $display("FAIL skip_frame_cnt: got %0d want 2", if_a.frame_cnt); end
        n_checks++; if (if_a.line_width !== 12'd4) begin n_fail++; $display("FAIL skip_line_width: got %0d want 4", if_a.line_width); end
        n_checks++; if (if_a.pix_x !== 12'd3 || if_a.pix_y !== 12'd3) begin n_fail++; $display("FAIL last_pix_xy: got %0d,%0d want 3,3", if_a.pix_x, if_a.pix_y); end
        n_checks++; if (if_a.pix_data !== 16'h3637) begin n_fail++; $display("FAIL last_pix_data: got %0h want 3637", if_a.pix_data); end
        n_checks++; if (ep_a !== 0) begin n_fail++; $display("FAIL skip_err_partial: got %0d want 0", ep_a); end
        n_checks++; if (fe_c !== 2 || if_c.frame_cnt !== 8'd2) begin n_fail++; $display("FAIL inv_frame_cnt: got %0d/%0d want 2/2", fe_c, if_c.frame_cnt); end
        n_checks++; if (if_c.line_width !== 12'd4) begin n_fail++; $display("FAIL inv_line_width: got %0d want 4", if_c.line_width); end
        n_checks++; if (fe_b !== 4 || if_b.frame_cnt !== 8'd4) begin n_fail++; $display("FAIL noskip_frames: got %0d/%0d want 4/4", fe_b, if_b.frame_cnt); end
        n_checks++; if (if_b.line_width !== 12'd2) begin n_fail++; $display("FAIL noskip_line_width: got %0d want 2", if_b.line_width); end
    endtask

    task automatic test_pixel_order();
        frame_head();
        cyc(1'b1, 1'b1, 8'hA1);
        cyc(1'b1, 1'b1, 8'hB2);
        cyc(1'b1, 1'b0, 8'h00);
        n_checks++; if (if_a.pix_valid !== 1'b0) begin n_fail++; $display("FAIL order_early_valid: got %0b want 0", if_a.pix_valid); end
        cyc(1'b1, 1'b0, 8'h00);
        n_checks++; if (if_a.pix_valid !== 1'b1) begin n_fail++; $display("FAIL order_valid: got %0b want 1", if_a.pix_valid); end
        n_checks++; if (if_a.pix_data !== 16'hA1B2) begin n_fail++; $display("FAIL order_data: got %0h want a1b2", if_a.pix_data); end
        n_checks++; if (if_a.pix_x !== 12'd0 || if_a.pix_y !== 12'd0) begin n_fail++; $display("FAIL order_xy: got %0d,%0d want 0,0", if_a.pix_x, if_a.pix_y); end
        n_checks++; if (if_c.pix_valid !== 1'b1 || if_c.pix_data !== 16'hA1B2) begin n_fail++; $display("FAIL inv_order: got %0b/%0h want 1/a1b2", if_c.pix_valid, if_c.pix_data); end
        cyc(1'b1, 1'b0, 8'h00);
        n_checks++; if (if_a.pix_valid !== 1'b0) begin n_fail++; $display("FAIL order_strobe_len: got %0b want 0", if_a.pix_valid); end
        n_checks++; if (if_a.pix_data !== 16'hA1B2) begin n_fail++; $display("FAIL order_hold: got %0h want a1b2", if_a.pix_data); end
        frame_tail();
        n_checks++; if (if_a.frame_cnt !== 8'd3) begin n_fail++; $display("FAIL order_frame_cnt: got %0d want 3", if_a.frame_cnt); end
        n_checks++; if (if_a.line_width !== 12'd1) begin n_fail++; $display("FAIL order_line_width: got %0d want 1", if_a.line_width); end
    endtask

    task automatic test_partial();
        int s_pv, s_ep, s_le;
        s_pv = pv_b; s_ep = ep_b; s_le = le_b;
        send_frame(1, 7);
        n_checks++; if (pv_b - s_pv !== 2) begin n_fail++; $display("FAIL partial_pixels: got %0d want 2", pv_b - s_pv); end
        n_checks++; if (ep_b - s_ep !== 1) begin n_fail++; $display("FAIL partial_err: got %0d want 1", ep_b - s_ep); end
        n_checks++; if (le_b - s_le !== 1) begin n_fail++; $display("FAIL partial_line_end: got %0d want 1", le_b - s_le); end
        n_checks++; if (eps_b !== 0) begin n_fail++; $display("FAIL partial_err_alone: got %0d want 0", eps_b); end
        n_checks++; if (if_b.line_width !== 12'd2) begin n_fail++; $display("FAIL partial_line_width: got %0d want 2", if_b.line_width); end
        n_checks++; if (if_b.pix_data !== 24'h030405) begin n_fail++; $display("FAIL partial_pix_data: got %0h want 030405", if_b.pix_data); end
        n_checks++; if (if_b.frame_cnt !== 8'd6) begin n_fail++; $display("FAIL partial_frame_cnt: got %0d want 6", if_b.frame_cnt); end
    endtask

    task automatic test_cfg_drop();
        int s_fs, s_fe, s_pv;
        s_fe = fe_a;
        frame_head();
        send_line(0, 8);
        cfg_en = 1'b0;
        for (int l = 1; l < 4; l++) send_line(l, 8);
        frame_tail();
        n_checks++; if (fe_a - s_fe !== 1) begin n_fail++; $display("FAIL cfgdrop_frame_end: got %0d want 1", fe_a - s_fe); end
        n_checks++; if (if_a.frame_cnt !== 8'd5) begin n_fail++; $display("FAIL cfgdrop_frame_cnt: got %0d want 5", if_a.frame_cnt); end
        s_fs = fs_a; s_fe = fe_a; s_pv = pv_a;
        send_frame(4, 8);
        n_checks++; if (fs_a - s_fs !== 0 || fe_a - s_fe !== 0) begin n_fail++; $display("FAIL cfgdrop_idle_strobes: got %0d/%0d want 0/0", fs_a - s_fs, fe_a - s_fe); end
        n_checks++; if (pv_a - s_pv !== 0) begin n_fail++; $display("FAIL cfgdrop_idle_pixels: got %0d want 0", pv_a - s_pv); end
    endtask

    task automatic test_reset_mid();
        int s_fs, s_fe;
        cfg_en = 1'b1;
        frame_head();
        send_line(0, 8);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'(16 + i));
        #2 rst = 1'b1;
        #1;
        n_checks++; if (if_a.frame_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_frame_cnt: got %0d want 0", if_a.frame_cnt); end
        n_checks++; if (if_a.line_width !== 12'd0) begin n_fail++; $display("FAIL rstmid_line_width: got %0d want 0", if_a.line_width); end
        n_checks++; if (if_a.pix_data !== 16'h0 || if_a.pix_x !== 12'd0) begin n_fail++; $display("FAIL rstmid_pix: got %0h/%0d want 0/0", if_a.pix_data, if_a.pix_x); end
        n_checks++; if (if_b.frame_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_b_frame_cnt: got %0d want 0", if_b.frame_cnt); end
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        repeat (2) cyc(1'b0, 1'b0, 8'h00);
        s_fs = fs_a;
        send_frame(4, 8);
        send_frame(4, 8);
        n_checks++; if (fs_a - s_fs !== 0) begin n_fail++; $display("FAIL rstmid_reskip: got %0d want 0", fs_a - s_fs); end
        s_fs = fs_a; s_fe = fe_a;
        send_frame(4, 8);
        n_checks++; if (fs_a - s_fs !== 1 || fe_a - s_fe !== 1) begin n_fail++; $display("FAIL rstmid_capture: got %0d/%0d want 1/1", fs_a - s_fs, fe_a - s_fe); end
        n_checks++; if (if_a.frame_cnt !== 8'd1) begin n_fail++; $display("FAIL rstmid_frame_cnt_after: got %0d want 1", if_a.frame_cnt); end
    endtask

    task automatic test_init_drop();
        int s_fs, s_fe;
        s_fs = fs_a; s_fe = fe_a;
        frame_head();
        send_line(0, 8);
        init_done = 1'b0;
        send_line(1, 8);
        frame_tail();
        n_checks++; if (fs_a - s_fs !== 1) begin n_fail++; $display("FAIL initdrop_frame_start: got %0d want 1", fs_a - s_fs); end
        n_checks++; if (fe_a - s_fe !== 0) begin n_fail++; $display("FAIL initdrop_frame_end: got %0d want 0", fe_a - s_fe); end
        n_checks++; if (if_a.frame_cnt !== 8'd1) begin n_fail++; $display("FAIL initdrop_frame_cnt: got %0d want 1", if_a.frame_cnt); end
        init_done = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_skip_capture();
        test_pixel_order();
        test_partial();
        test_cfg_drop();
        test_reset_mid();
        test_init_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
